// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel timer.
//   chan_state_t : per-channel state (IDLE, COUNTING)
//   SYNC_DEPTH   : number of flops in the button synchronizer
package timer_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        COUNTING = 1'b1
    } chan_state_t;

    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: counts up from 0 to a programmable terminal value.
// Ports:
//   Clk, Reset     clock and synchronous active-high reset
//   start          start/restart strobe (already combined with the button)
//   stop           abort strobe, returns to IDLE with count 0
//   load           writes load_value into the terminal register
//   load_value     new terminal value
//   auto_reload    0 = one-shot, 1 = wrap to 0 at the terminal value
//   count_active   high while COUNTING
//   count_end      one-cycle registered pulse at the terminal value
//   count          current count
//
// state    | meaning
// ---------+------------------------------------------------------
// IDLE     | not counting; count holds its last value (0 after stop)
// COUNTING | count advances each edge until it reaches TERM
module timer_channel
    import timer_pkg::*;
#(
    parameter int N = 5
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         start,
    input  logic         stop,
    input  logic         load,
    input  logic [N-1:0] load_value,
    input  logic         auto_reload,
    output logic         count_active,
    output logic         count_end,
    output logic [N-1:0] count
);

    chan_state_t  state;
    logic [N-1:0] term;

    assign count_active = (state == COUNTING);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            count     <= '0;
            term      <= '1;
            count_end <= 1'b0;
        end else begin
            // TERM update is outside the stop/start priority; the compare
            // below still sees the old value on this edge.
            if (load) begin
                term <= load_value;
            end
            count_end <= 1'b0;
            if (stop) begin
                state <= IDLE;
                count <= '0;
            end else if (start) begin
                state <= COUNTING;
                count <= '0;
            end else if (state == COUNTING) begin
                // >= rather than == so a lowered TERM ends the count
                // instead of letting it run to wrap-around.
                if (count >= term) begin
                    count_end <= 1'b1;
                    if (auto_reload) begin
                        count <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end else begin
                    count <= count + N'(1);
                end
            end
        end
    end

endmodule

// File: rtl/multi_timer.sv
// Multi-channel timer with a shared, debounced push-button start.
// Ports:
//   Clk, Reset     clock and synchronous active-high reset
//   button         raw active-low push button (asynchronous)
//   start_mask     channels started by a button press
//   soft_start     per-channel start strobe
//   stop           per-channel abort strobe
//   load           per-channel terminal-value write strobe
//   load_value     shared terminal value for load
//   auto_reload    per-channel one-shot (0) / auto-reload (1) mode
//   start_pulse    one-cycle pulse per button press
//   count_active   per-channel COUNTING flag
//   count_end      per-channel terminal pulse
//   count_t        packed counts, channel i at [i*N +: N]
module multi_timer
    import timer_pkg::*;
#(
    parameter int N        = 5,
    parameter int CHANNELS = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  button,
    input  logic [CHANNELS-1:0]   start_mask,
    input  logic [CHANNELS-1:0]   soft_start,
    input  logic [CHANNELS-1:0]   stop,
    input  logic [CHANNELS-1:0]   load,
    input  logic [N-1:0]          load_value,
    input  logic [CHANNELS-1:0]   auto_reload,
    output logic                  start_pulse,
    output logic [CHANNELS-1:0]   count_active,
    output logic [CHANNELS-1:0]   count_end,
    output logic [CHANNELS*N-1:0] count_t
);

    logic [SYNC_DEPTH-1:0] sync;
    logic [SYNC_DEPTH-1:0] filled;
    logic                  prev_level;
    logic                  armed;
    logic                  level;
    logic [CHANNELS-1:0]   start_eff;

    assign level = sync[SYNC_DEPTH-1];

    // The synchronizer resets to "released", so a button already held low
    // at reset would look like a fresh press. 'filled' marks when the last
    // sync flop holds a real sample; 'armed' is only set once a real
    // released level has been seen, which blocks that false press.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync        <= '1;
            filled      <= '0;
            prev_level  <= 1'b1;
            armed       <= 1'b0;
            start_pulse <= 1'b0;
        end else begin
            sync        <= {sync[SYNC_DEPTH-2:0], button};
            filled      <= {filled[SYNC_DEPTH-2:0], 1'b1};
            prev_level  <= level;
            armed       <= armed | (filled[SYNC_DEPTH-1] & level);
            start_pulse <= armed & prev_level & ~level;
        end
    end

    assign start_eff = soft_start | ({CHANNELS{start_pulse}} & start_mask);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        timer_channel #(
            .N(N)
        ) u_ch (
            .Clk          (Clk),
            .Reset        (Reset),
            .start        (start_eff[i]),
            .stop         (stop[i]),
            .load         (load[i]),
            .load_value   (load_value),
            .auto_reload  (auto_reload[i]),
            .count_active (count_active[i]),
            .count_end    (count_end[i]),
            .count        (count_t[i*N +: N])
        );
    end

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: directed scenarios plus a randomized
// run, all compared against a cycle-level behavioural model.
module tb_multi_timer;

    localparam int N  = 5;
    localparam int CH = 4;
    localparam int BW = 1 + 2*CH + CH*N;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            button;
    logic [CH-1:0]   start_mask, soft_start, stop, load, auto_reload;
    logic [N-1:0]    load_value;
    logic            start_pulse;
    logic [CH-1:0]   count_active, count_end;
    logic [CH*N-1:0] count_t;

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model
    int m_count[CH];
    int m_term[CH];
    bit m_active[CH];
    bit m_end[CH];
    bit m_pulse;
    bit hist[$];   // button samples taken at each edge since reset

    multi_timer #(.N(N), .CHANNELS(CH)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .button       (button),
        .start_mask   (start_mask),
        .soft_start   (soft_start),
        .stop         (stop),
        .load         (load),
        .load_value   (load_value),
        .auto_reload  (auto_reload),
        .start_pulse  (start_pulse),
        .count_active (count_active),
        .count_end    (count_end),
        .count_t      (count_t)
    );

    always #5 Clk = ~Clk;

    function automatic logic [BW-1:0] exp_bundle();
        logic [CH*N-1:0] ct;
        logic [CH-1:0]   act, ce;
        for (int i = 0; i < CH; i++) begin
            ct[i*N +: N] = N'(m_count[i]);
            act[i]       = m_active[i];
            ce[i]        = m_end[i];
        end
        return {m_pulse, act, ce, ct};
    endfunction

    // Advance one clock and update the model from the inputs seen at the edge.
    task automatic tick();
        bit p_old;
        bit st;
        int e;
        int new_term;
        @(posedge Clk);
        if (Reset) begin
            for (int i = 0; i < CH; i++) begin
                m_count[i]  = 0;
                m_term[i]   = (1 << N) - 1;
                m_active[i] = 0;
                m_end[i]    = 0;
            end
            m_pulse = 0;
            hist.delete();
        end else begin
            p_old = m_pulse;
            hist.push_back(button);
            e = hist.size();
            // press seen when the sample two edges back is low and the one
            // before it is high, both taken after reset
            m_pulse = (e >= 4) && (hist[e-3] == 1'b0) && (hist[e-4] == 1'b1);
            for (int i = 0; i < CH; i++) begin
                st       = soft_start[i] | (p_old & start_mask[i]);
                new_term = load[i] ? int'(load_value) : m_term[i];
                m_end[i] = 0;
                if (stop[i]) begin
                    m_active[i] = 0;
                    m_count[i]  = 0;
                end else if (st) begin
                    m_active[i] = 1;
                    m_count[i]  = 0;
                end else if (m_active[i]) begin
                    if (m_count[i] >= m_term[i]) begin
                        m_end[i] = 1;
                        if (auto_reload[i]) m_count[i] = 0;
                        else                m_active[i] = 0;
                    end else begin
                        m_count[i] = m_count[i] + 1;
                    end
                end
                m_term[i] = new_term;
            end
        end
        #1;
    endtask

    task automatic clear_strobes();
        soft_start = '0;
        stop       = '0;
        load       = '0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; button = 1'b1; start_mask = '0; auto_reload = '0;
        load_value = '0; clear_strobes();
        tick(); tick();
        n_cmp++;
        if ({start_pulse, count_active, count_end, count_t} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got %h want 0", {start_pulse, count_active, count_end, count_t});
        end
        Reset = 1'b0;
        tick(); tick(); tick();
        n_cmp++;
        if ({start_pulse, count_active, count_end, count_t} !== exp_bundle()) begin
            n_err++;
            $display("FAIL reset_model: got %h want %h", {start_pulse, count_active, count_end, count_t}, exp_bundle());
        end
    endtask

    task automatic test_oneshot();
        load[0] = 1'b1; load_value = 5'd3; tick(); load = '0;
        soft_start[0] = 1'b1; tick(); soft_start = '0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            n_cmp++;
            if (count_t[N-1:0] !== N'(k) || count_active[0] !== 1'b1 || count_end[0] !== 1'b0) begin
                n_err++;
                $display("FAIL oneshot_count k=%0d: got cnt=%0d act=%b end=%b want cnt=%0d act=1 end=0",
                         k, count_t[N-1:0], count_active[0], count_end[0], k);
            end
        end
        tick();
        n_cmp++;
        if (count_end[0] !== 1'b1 || count_active[0] !== 1'b0 || count_t[N-1:0] !== 5'd3) begin
            n_err++;
            $display("FAIL oneshot_end: got end=%b act=%b cnt=%0d want end=1 act=0 cnt=3",
                     count_end[0], count_active[0], count_t[N-1:0]);
        end
        tick();
        n_cmp++;
        if (count_end[0] !== 1'b0 || count_t[N-1:0] !== 5'd3 || count_active[0] !== 1'b0) begin
            n_err++;
            $display("FAIL oneshot_hold: got end=%b act=%b cnt=%0d want end=0 act=0 cnt=3",
                     count_end[0], count_active[0], count_t[N-1:0]);
        end
    endtask

    task automatic test_auto_reload();
        auto_reload[1] = 1'b1;
        load[1] = 1'b1; load_value = 5'd2; tick(); load = '0;
        soft_start[1] = 1'b1; tick(); soft_start = '0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            n_cmp++;
            if (count_t[N +: N] !== N'(k % 3) || count_end[1] !== ((k % 3) == 0) || count_active[1] !== 1'b1) begin
                n_err++;
                $display("FAIL autoreload k=%0d: got cnt=%0d end=%b act=%b want cnt=%0d end=%b act=1",
                         k, count_t[N +: N], count_end[1], count_active[1], k % 3, (k % 3) == 0);
            end
        end
        stop[1] = 1'b1; tick(); stop = '0; auto_reload = '0;
        n_cmp++;
        if ({start_pulse, count_active, count_end, count_t} !== exp_bundle()) begin
            n_err++;
            $display("FAIL autoreload_model: got %h want %h", {start_pulse, count_active, count_end, count_t}, exp_bundle());
        end
    endtask

    task automatic test_button();
        int pulses = 0;
        int pulse_at = -1;
        start_mask = 4'b0101;
        button = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (start_pulse) begin
                pulses++;
                pulse_at = k;
            end
            if (k == 4) begin
                n_cmp++;
                if (count_active !== 4'b0101) begin
                    n_err++;
                    $display("FAIL button_channels: got %b want 0101", count_active);
                end
            end
        end
        n_cmp++;
        if (pulses != 1 || pulse_at != 3) begin
            n_err++;
            $display("FAIL button_pulse: got pulses=%0d at=%0d want pulses=1 at=3", pulses, pulse_at);
        end
        button = 1'b1; start_mask = '0;
        tick(); tick(); tick();
        n_cmp++;
        if ({start_pulse, count_active, count_end, count_t} !== exp_bundle()) begin
            n_err++;
            $display("FAIL button_model: got %h want %h", {start_pulse, count_active, count_end, count_t}, exp_bundle());
        end
    endtask

    task automatic test_stop_start();
        tick(); tick();
        stop[2] = 1'b1; soft_start[2] = 1'b1; tick(); clear_strobes();
        n_cmp++;
        if (count_active[2] !== 1'b0 || count_t[2*N +: N] !== '0 || count_end[2] !== 1'b0) begin
            n_err++;
            $display("FAIL stop_start: got act=%b cnt=%0d end=%b want act=0 cnt=0 end=0",
                     count_active[2], count_t[2*N +: N], count_end[2]);
        end
        tick();
        n_cmp++;
        if (count_active[2] !== 1'b0 || count_end[2] !== 1'b0) begin
            n_err++;
            $display("FAIL stop_start_after: got act=%b end=%b want act=0 end=0", count_active[2], count_end[2]);
        end
    endtask

    task automatic test_back_to_back();
        soft_start[0] = 1'b1; tick(); soft_start = '0;
        tick(); tick();
        soft_start[0] = 1'b1; tick(); soft_start = '0;
        n_cmp++;
        if (count_t[N-1:0] !== '0 || count_end[0] !== 1'b0 || count_active[0] !== 1'b1) begin
            n_err++;
            $display("FAIL restart: got cnt=%0d end=%b act=%b want cnt=0 end=0 act=1",
                     count_t[N-1:0], count_end[0], count_active[0]);
        end
        tick(); tick(); tick(); tick();
        n_cmp++;
        if (count_end[0] !== 1'b1 || count_t[N-1:0] !== 5'd3) begin
            n_err++;
            $display("FAIL restart_end: got end=%b cnt=%0d want end=1 cnt=3", count_end[0], count_t[N-1:0]);
        end
    endtask

    task automatic test_load_lower();
        load[3] = 1'b1; load_value = 5'd7; tick(); load = '0;
        soft_start[3] = 1'b1; tick(); soft_start = '0;
        tick(); tick(); tick(); tick();
        n_cmp++;
        if (count_t[3*N +: N] !== 5'd4) begin
            n_err++;
            $display("FAIL lower_pre: got cnt=%0d want 4", count_t[3*N +: N]);
        end
        load[3] = 1'b1; load_value = 5'd2; tick(); load = '0;
        n_cmp++;
        if (count_t[3*N +: N] !== 5'd5 || count_end[3] !== 1'b0 || count_active[3] !== 1'b1) begin
            n_err++;
            $display("FAIL lower_load: got cnt=%0d end=%b act=%b want cnt=5 end=0 act=1",
                     count_t[3*N +: N], count_end[3], count_active[3]);
        end
        tick();
        n_cmp++;
        if (count_t[3*N +: N] !== 5'd5 || count_end[3] !== 1'b1 || count_active[3] !== 1'b0) begin
            n_err++;
            $display("FAIL lower_end: got cnt=%0d end=%b act=%b want cnt=5 end=1 act=0",
                     count_t[3*N +: N], count_end[3], count_active[3]);
        end
    endtask

    task automatic test_reset_midcount();
        int ends_seen = 0;
        load[0] = 1'b1; load_value = 5'd10; tick(); load = '0;
        soft_start[0] = 1'b1; tick(); soft_start = '0;
        tick(); tick(); tick(); tick();
        Reset = 1'b1; tick(); Reset = 1'b0;
        n_cmp++;
        if (count_t[N-1:0] !== '0 || count_active[0] !== 1'b0 || count_end !== '0) begin
            n_err++;
            $display("FAIL reset_mid: got cnt=%0d act=%b end=%b want cnt=0 act=0 end=0",
                     count_t[N-1:0], count_active[0], count_end);
        end
        soft_start[0] = 1'b1; tick(); soft_start = '0;
        for (int k = 0; k < 31; k++) begin
            tick();
            if (count_end[0]) ends_seen++;
        end
        n_cmp++;
        if (ends_seen != 0 || count_t[N-1:0] !== 5'd31 || count_active[0] !== 1'b1) begin
            n_err++;
            $display("FAIL reset_term_run: got ends=%0d cnt=%0d act=%b want ends=0 cnt=31 act=1",
                     ends_seen, count_t[N-1:0], count_active[0]);
        end
        tick();
        n_cmp++;
        if (count_end[0] !== 1'b1 || count_t[N-1:0] !== 5'd31 || count_active[0] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_term_end: got end=%b cnt=%0d act=%b want end=1 cnt=31 act=0",
                     count_end[0], count_t[N-1:0], count_active[0]);
        end
    endtask

    task automatic test_button_after_reset();
        int pulses = 0;
        int pulse_at = -1;
        button = 1'b0; Reset = 1'b1; tick(); Reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (start_pulse) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_err++;
            $display("FAIL held_after_reset: got pulses=%0d want 0", pulses);
        end
        button = 1'b1; tick(); tick(); tick();
        button = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (start_pulse) begin
                pulses++;
                pulse_at = k;
            end
        end
        n_cmp++;
        if (pulses != 1 || pulse_at != 3) begin
            n_err++;
            $display("FAIL repress_after_reset: got pulses=%0d at=%0d want 1 at 3", pulses, pulse_at);
        end
        button = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            Reset = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 5) == 0) button = ~button;
            start_mask = CH'($urandom);
            load_value = N'($urandom_range(0, 9));
            for (int i = 0; i < CH; i++) begin
                soft_start[i]  = ($urandom_range(0, 15) == 0);
                stop[i]        = ($urandom_range(0, 29) == 0);
                load[i]        = ($urandom_range(0, 9) == 0);
                auto_reload[i] = ($urandom_range(0, 2) == 0);
            end
            tick();
            n_cmp++;
            if ({start_pulse, count_active, count_end, count_t} !== exp_bundle()) begin
                n_err++;
                $display("FAIL random cyc=%0d: got %h want %h", c,
                         {start_pulse, count_active, count_end, count_t}, exp_bundle());
            end
        end
        Reset = 1'b0;
        clear_strobes();
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_auto_reload();
        test_button();
        test_stop_start();
        test_back_to_back();
        test_load_lower();
        test_reset_midcount();
        test_button_after_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
